pa_hash_engine: RTL and testbench

PA_HASH_ENGINE -- requirements
Module: pa_hash_engine

---
 rtl/pa_hash_engine.sv | 150 +++++++++++++++
 tb/tb_pa_hash_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pa_hash_engine.sv
`default_nettype none
// ============================================================================
// Module      : pa_hash_engine
// Description : Privacy-amplification hash engine. Each block of K key words
//               is multiplied (over GF(2)) by M matrix rows per word. A row
//               j folds the parity of (key AND row) into accumulator bit j.
//               After the last row of the last word the M-bit result is
//               presented until it is accepted.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               key_in/valid/ready  - N-bit key word stream (input)
//               row_in/valid/ready  - N-bit matrix row stream (input)
//               hash_out/valid/ready- M-bit block hash (output)
//               busy             - block in progress or result pending
// Revision    : 1.0 - initial release
// ============================================================================
module pa_hash_engine #(
    parameter int N = 128,
    parameter int M = 64,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [N-1:0] row_in,
    input  logic         row_valid,
    output logic         row_ready,
    output logic [M-1:0] hash_out,
    output logic         hash_valid,
    input  logic         hash_ready,
    output logic         busy
);

    localparam int c_WCNT_W = (K > 1) ? $clog2(K) : 1;
    localparam int c_RCNT_W = (M > 1) ? $clog2(M) : 1;

    localparam logic [c_WCNT_W-1:0] c_WLAST = c_WCNT_W'(K - 1);
    localparam logic [c_RCNT_W-1:0] c_RLAST = c_RCNT_W'(M - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ROWS = 2'd1;
    localparam logic [1:0] c_OUT  = 2'd2;

    logic [1:0]          r_state;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic [c_RCNT_W-1:0] r_rcnt;
    logic [M-1:0]        r_acc;
    logic [N-1:0]        r_key;

    logic [1:0]          w_state_nxt;
    logic [c_WCNT_W-1:0] w_wcnt_nxt;
    logic [c_RCNT_W-1:0] w_rcnt_nxt;
    logic [M-1:0]        w_acc_nxt;
    logic [N-1:0]        w_key_nxt;
    logic                w_key_rdy;
    logic                w_row_rdy;
    logic                w_hash_vld;
    logic                w_row_par;
    logic [M-1:0]        w_rmask;

    // GF(2) inner product of the current key word with the incoming row.
    assign w_row_par = ^(r_key & row_in);

    // One-hot select of the accumulator bit addressed by the row counter.
    always_comb begin
        w_rmask = '0;
        for (int i = 0; i < M; i++) begin
            w_rmask[i] = (r_rcnt == c_RCNT_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
            r_acc   <= '0;
            r_key   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_acc   <= w_acc_nxt;
            r_key   <= w_key_nxt;
        end
    end

    // Ready/valid are masked while rst is high so no transfer can be
    // observed on a reset cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_rcnt_nxt  = r_rcnt;
        w_acc_nxt   = r_acc;
        w_key_nxt   = r_key;
        w_key_rdy   = 1'b0;
        w_row_rdy   = 1'b0;
        w_hash_vld  = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_key_rdy = ~rst;
                if (key_valid && w_key_rdy) begin
                    w_key_nxt   = key_in;
                    w_rcnt_nxt  = '0;
                    w_state_nxt = c_ROWS;
                    // First word of a block starts from a clean accumulator.
                    if (r_wcnt == '0) begin
                        w_acc_nxt = '0;
                    end
                end
            end
            c_ROWS: begin
                w_row_rdy = ~rst;
                if (row_valid && w_row_rdy) begin
                    w_acc_nxt = r_acc ^ (w_rmask & {M{w_row_par}});
                    if (r_rcnt == c_RLAST) begin
                        w_rcnt_nxt = '0;
                        if (r_wcnt == c_WLAST) begin
                            w_wcnt_nxt  = '0;
                            w_state_nxt = c_OUT;
                        end else begin
                            w_wcnt_nxt  = r_wcnt + 1'b1;
                            w_state_nxt = c_IDLE;
                        end
                    end else begin
                        w_rcnt_nxt = r_rcnt + 1'b1;
                    end
                end
            end
            c_OUT: begin
                w_hash_vld = ~rst;
                if (hash_ready && w_hash_vld) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign key_ready  = w_key_rdy;
    assign row_ready  = w_row_rdy;
    assign hash_valid = w_hash_vld;
    assign hash_out   = (r_state == c_OUT) ? r_acc : {M{1'b0}};
    assign busy       = (r_state != c_IDLE) || (r_wcnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_pa_hash_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_pa_hash_engine
// Description : Bench for pa_hash_engine with two instances: A (N=8,M=2,K=1)
//               and B (N=8,M=2,K=2). Directed stimulus pushes hand-computed
//               hashes into per-instance queues; monitors pop and compare on
//               each accepted result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pa_hash_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] a_key_in, a_row_in, b_key_in, b_row_in;
    logic       a_key_valid, a_key_ready, a_row_valid, a_row_ready;
    logic       b_key_valid, b_key_ready, b_row_valid, b_row_ready;
    logic [1:0] a_hash_out, b_hash_out;
    logic       a_hash_valid, a_hash_ready, a_busy;
    logic       b_hash_valid, b_hash_ready, b_busy;

    int checks   = 0;
    int failures = 0;

    logic [1:0] a_q[$];
    logic [1:0] b_q[$];

    pa_hash_engine #(.N(8), .M(2), .K(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .key_in(a_key_in), .key_valid(a_key_valid), .key_ready(a_key_ready),
        .row_in(a_row_in), .row_valid(a_row_valid), .row_ready(a_row_ready),
        .hash_out(a_hash_out), .hash_valid(a_hash_valid), .hash_ready(a_hash_ready),
        .busy(a_busy)
    );

    pa_hash_engine #(.N(8), .M(2), .K(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .key_in(b_key_in), .key_valid(b_key_valid), .key_ready(b_key_ready),
        .row_in(b_row_in), .row_valid(b_row_valid), .row_ready(b_row_ready),
        .hash_out(b_hash_out), .hash_valid(b_hash_valid), .hash_ready(b_hash_ready),
        .busy(b_busy)
    );

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    function automatic void timeout(string nm);
        checks++;
        failures++;
        $display("FAIL %s timeout actual=waiting expected=handshake", nm);
    endfunction

    // Result monitors: sample on the falling edge, away from state updates.
    always @(negedge clk) begin
        if (!rst && a_hash_valid && a_hash_ready) begin
            if (a_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_hash actual=%b expected=none", a_hash_out);
            end else begin
                chk("a_hash", int'(a_hash_out), int'(a_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_hash_valid && b_hash_ready) begin
            if (b_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_hash actual=%b expected=none", b_hash_out);
            end else begin
                chk("b_hash", int'(b_hash_out), int'(b_q.pop_front()));
            end
        end
    end

    // Handshake tasks: entered and left 1 time unit after a rising edge.
    task automatic a_key(input logic [7:0] k);
        int n = 0;
        a_key_in = k; a_key_valid = 1'b1;
        while (!a_key_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) timeout("a_key");
        @(posedge clk); #1;
        a_key_valid = 1'b0; a_key_in = 8'h5A;
    endtask

    task automatic a_row(input logic [7:0] r);
        int n = 0;
        a_row_in = r; a_row_valid = 1'b1;
        while (!a_row_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) timeout("a_row");
        @(posedge clk); #1;
        a_row_valid = 1'b0; a_row_in = 8'hFF;
    endtask

    task automatic b_key(input logic [7:0] k);
        int n = 0;
        b_key_in = k; b_key_valid = 1'b1;
        while (!b_key_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) timeout("b_key");
        @(posedge clk); #1;
        b_key_valid = 1'b0; b_key_in = 8'h5A;
    endtask

    task automatic b_row(input logic [7:0] r);
        int n = 0;
        b_row_in = r; b_row_valid = 1'b1;
        while (!b_row_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) timeout("b_row");
        @(posedge clk); #1;
        b_row_valid = 1'b0; b_row_in = 8'hFF;
    endtask

    task automatic wait_idle(input bit sel_b);
        int n = 0;
        while (n < 50 && (sel_b ? (b_busy || !b_key_ready) : (a_busy || !a_key_ready))) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) timeout(sel_b ? "b_idle" : "a_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_key_in = '0; a_key_valid = 0; a_row_in = '0; a_row_valid = 0; a_hash_ready = 1;
        b_key_in = '0; b_key_valid = 0; b_row_in = '0; b_row_valid = 0; b_hash_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_ready", a_key_ready, 0);
        chk("rst_row_ready", a_row_ready, 0);
        chk("rst_hash_valid", a_hash_valid, 0);
        chk("rst_hash_out", a_hash_out, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_b_key_ready", b_key_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_key_ready", a_key_ready, 1);

        // K=1 basic block with result backpressure: key FF, rows 01,03 -> 01.
        a_hash_ready = 0;
        a_q.push_back(2'b01);
        a_key(8'hFF);
        chk("a_busy_rows", a_busy, 1);
        a_row(8'h01);
        chk("a_no_early_valid", a_hash_valid, 0);
        a_row(8'h03);
        chk("a_latency_valid", a_hash_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hash_valid", a_hash_valid, 1);
            chk("bp_hash_out", a_hash_out, 1);
            chk("bp_key_ready", a_key_ready, 0);
            chk("bp_row_ready", a_row_ready, 0);
            @(posedge clk); #1;
        end
        a_hash_ready = 1;
        @(posedge clk); #1;
        chk("release_key_ready", a_key_ready, 1);
        chk("release_hash_valid", a_hash_valid, 0);
        chk("release_busy", a_busy, 0);

        // Back-to-back K=1 blocks; second key all-zero must give zero hash.
        a_q.push_back(2'b11);
        a_q.push_back(2'b00);
        a_key(8'hA5); a_row(8'h01); a_row(8'h04);
        a_key(8'h00); a_row(8'hFF); a_row(8'hFF);
        wait_idle(0);

        // Reset in the middle of a block discards it.
        a_key(8'hFF); a_row(8'h01);
        chk("mid_busy", a_busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_key_ready", a_key_ready, 0);
        chk("mid_rst_row_ready", a_row_ready, 0);
        chk("mid_rst_hash_valid", a_hash_valid, 0);
        chk("mid_rst_hash_out", a_hash_out, 0);
        chk("mid_rst_busy", a_busy, 0);
        rst = 1'b0;
        #1;
        chk("mid_post_key_ready", a_key_ready, 1);
        a_q.push_back(2'b01);
        a_key(8'hFF); a_row(8'h01); a_row(8'h03);
        wait_idle(0);

        // K=2: key 0F rows 01,00 ; key 0F rows 01,01 -> 10.
        b_q.push_back(2'b10);
        b_key(8'h0F); b_row(8'h01); b_row(8'h00);
        chk("b_between_busy", b_busy, 1);
        chk("b_between_key_ready", b_key_ready, 1);
        chk("b_between_hash_valid", b_hash_valid, 0);
        b_key(8'h0F); b_row(8'h01); b_row(8'h01);
        wait_idle(1);

        // K=2 with row_valid pattern 1,0,0,1; gap data must not be sampled.
        // Word 1: key 3C, rows 04 (par 1), 0C (par 0) -> acc 01.
        // Word 2: key 01, rows 00 (par 0), 01 (par 1) -> acc 11.
        b_q.push_back(2'b11);
        b_key(8'h3C);
        b_row_valid = 1; b_row_in = 8'h04;
        @(posedge clk); #1;
        b_row_valid = 0; b_row_in = 8'h08;
        chk("gap1_row_ready", b_row_ready, 1);
        @(posedge clk); #1;
        chk("gap2_row_ready", b_row_ready, 1);
        @(posedge clk); #1;
        chk("gap3_row_ready", b_row_ready, 1);
        b_row_valid = 1; b_row_in = 8'h0C;
        @(posedge clk); #1;
        b_row_valid = 0; b_row_in = 8'hFF;
        chk("gap_done_key_ready", b_key_ready, 1);
        chk("gap_done_row_ready", b_row_ready, 0);
        b_key(8'h01); b_row(8'h00); b_row(8'h01);
        wait_idle(1);

        repeat (2) @(posedge clk);
        #1;
        chk("a_queue_drained", a_q.size(), 0);
        chk("b_queue_drained", b_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
